accelerator_matrix_stream_source: RTL and testbench
===================================================

Name: accelerator_matrix_stream_source

Overview:
- Operand-side transmitter for the LSTM gate accelerators.
- Buffers one SIZE_I x SIZE_J matrix, loaded row-major, then streams it element by element to a gate in response to that gate's per-element requests.
- Drives the gate's DATA/I/J-enable inputs, e.g. W_IN, W_IN_L_ENABLE and W_IN_X_ENABLE.
- Consumes the gate's request output, e.g. W_OUT_X_ENABLE.

Parameters:
- DATA_SIZE, 64, width of data and size words.
- CONTROL_SIZE, 64, width of internal i/j counters.
- ADDRESS_SIZE, 8, buffer depth is 2**ADDRESS_SIZE words.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- START  in  1  begin load+stream transaction.
- READY  out  1  one-cycle pulse at transaction end.
- ERROR  out  1  valid with READY; high = size product exceeds buffer depth.
- SIZE_I_IN  in  DATA_SIZE  rows, sampled at START.
- SIZE_J_IN  in  DATA_SIZE  columns, sampled at START.
- LOAD_ENABLE  in  1  LOAD_DATA valid this cycle.
- LOAD_DATA  in  DATA_SIZE  matrix element, row-major.
- DATA_REQUEST_ENABLE  in  1  consumer asks for next element.
- DATA_OUT_I_ENABLE  out  1  pulse: element is first of a row.
- DATA_OUT_J_ENABLE  out  1  pulse: DATA_OUT valid.
- DATA_OUT  out  DATA_SIZE  streamed element; holds last value between pulses.

Behaviour:
- Reset (synchronous, RST=1 at clock edge):
  - READY, ERROR, DATA_OUT_I_ENABLE and DATA_OUT_J_ENABLE go to 0.
  - DATA_OUT goes to 0.
  - FSM goes to STARTER_STATE; counters go to 0.
  - Buffer contents are not cleared (don't-care).
  - Reset mid-transaction aborts it with no READY pulse.
- Enable outputs are single-cycle pulses, registered.
- STARTER_STATE:
  - READY=0.
  - On START=1: latch sizes, compute N = SIZE_I*SIZE_J at 2*DATA_SIZE width, clear wr pointer, i and j.
  - If SIZE_I=0 or SIZE_J=0: next cycle READY=1, ERROR=0, stay in STARTER_STATE.
  - Else if N > 2**ADDRESS_SIZE: next cycle READY=1, ERROR=1, stay in STARTER_STATE.
  - Else go to LOADING_STATE.
- LOADING_STATE:
  - Each cycle with LOAD_ENABLE=1: write buffer[wr]=LOAD_DATA, wr++.
  - Cycles with LOAD_ENABLE=0 are stalls.
  - On the write with wr==N-1: go to FIRST_STATE.
  - DATA_REQUEST_ENABLE is ignored here.
- FIRST_STATE (one cycle): next cycle DATA_OUT=buffer[0], DATA_OUT_I_ENABLE=1, DATA_OUT_J_ENABLE=1. Go to STREAM_STATE. The first element is unsolicited.
- STREAM_STATE, on DATA_REQUEST_ENABLE=1:
  - If j<SIZE_J-1: j++, emit buffer[i*SIZE_J+j] next cycle with J enable only.
  - Else if i<SIZE_I-1: j=0, i++, emit next cycle with I and J enables.
  - Else (last element already sent): next cycle READY=1, ERROR=0, no element emitted, go to STARTER_STATE.
- Request latency: exactly 1 cycle from request to output.
- Back-to-back requests every cycle are accepted, including a request in the same cycle as an output pulse.
- START while not in STARTER_STATE is ignored.
- LOAD_ENABLE outside LOADING_STATE is ignored; it does not write the buffer.
- The read address is computed with a running offset, not a multiplier. Only the size product uses multiplication.
- Size inputs are ignored after START; changing them mid-transaction has no effect.

Test Plan:
- Reset values: RST=1 for 2 cycles mid-stream of a 2x2 matrix. Required: all outputs 0 next cycle, no READY pulse. A new START then works normally.
- 2x3 stream: load 10,11,12,20,21,22, then requests every cycle. Required output sequence with (I,J) enables:
  - 10 (1,1), 11 (0,1), 12 (0,1)
  - 20 (1,1), 21 (0,1), 22 (0,1)
  - then READY=1, ERROR=0 one cycle after the 6th request.
- Stalls: load 1x4 with LOAD_ENABLE gaps of 2 cycles, and requests spaced 3 cycles apart. Required:
  - no extra writes;
  - each element appears exactly 1 cycle after its request;
  - DATA_OUT holds between pulses.
- Zero size: SIZE_I=0, SIZE_J=5, START. Required: READY=1, ERROR=0 on the next cycle; no enables asserted.
- Overflow: ADDRESS_SIZE=8, SIZE_I=17, SIZE_J=16 (N=272 > 256). Required: READY=1, ERROR=1 next cycle; LOAD_ENABLE ignored afterwards.
- Ignored inputs:
  - START pulses during LOADING_STATE/STREAM_STATE, LOAD_ENABLE during STREAM_STATE, and requests during LOADING_STATE. Required: sequence identical to the 2x3 case.
  - Exact fit 16x16=256: all 256 elements stream in order.

Source files
------------

// File: rtl/accelerator_matrix_stream_source.sv
// Operand-side transmitter for the LSTM gate accelerators: buffers one row-major
// SIZE_I x SIZE_J matrix, then streams it element by element on the gate's requests.
module accelerator_matrix_stream_source #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64,
  parameter int unsigned ADDRESS_SIZE = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 ERROR,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic                 LOAD_ENABLE,
  input  logic [DATA_SIZE-1:0] LOAD_DATA,
  input  logic                 DATA_REQUEST_ENABLE,
  output logic                 DATA_OUT_I_ENABLE,
  output logic                 DATA_OUT_J_ENABLE,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam int unsigned ProdW = 2 * DATA_SIZE;
  localparam logic [ProdW-1:0] Depth = ProdW'(1) << ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE-1:0] AddrZero = '0;

  typedef enum logic [1:0] {StStarter, StLoading, StFirst, StStream} state_e;

  state_e                  state_q;
  logic [DATA_SIZE-1:0]    mem_q [2**ADDRESS_SIZE];
  logic [ProdW-1:0]        n_last_q;
  logic [CONTROL_SIZE-1:0] last_i_q, last_j_q, row_step_q;
  logic [CONTROL_SIZE-1:0] wr_q, i_q, j_q, offset_q;

  logic [ProdW-1:0]        prod;
  logic [ADDRESS_SIZE-1:0] wr_addr, addr_next_j, addr_next_row;

  // offset_q tracks i*SIZE_J incrementally so the read path needs no multiplier.
  always_comb begin
    prod          = ProdW'(SIZE_I_IN) * ProdW'(SIZE_J_IN);
    wr_addr       = ADDRESS_SIZE'(wr_q);
    addr_next_j   = ADDRESS_SIZE'(offset_q + j_q + CONTROL_SIZE'(1));
    addr_next_row = ADDRESS_SIZE'(offset_q + row_step_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST && state_q == StLoading && LOAD_ENABLE) begin
      mem_q[wr_addr] <= LOAD_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q           <= StStarter;
      READY             <= 1'b0;
      ERROR             <= 1'b0;
      DATA_OUT_I_ENABLE <= 1'b0;
      DATA_OUT_J_ENABLE <= 1'b0;
      DATA_OUT          <= '0;
      n_last_q          <= '0;
      last_i_q          <= '0;
      last_j_q          <= '0;
      row_step_q        <= '0;
      wr_q              <= '0;
      i_q               <= '0;
      j_q               <= '0;
      offset_q          <= '0;
    end else begin
      READY             <= 1'b0;
      ERROR             <= 1'b0;
      DATA_OUT_I_ENABLE <= 1'b0;
      DATA_OUT_J_ENABLE <= 1'b0;
      case (state_q)
        StStarter: begin
          if (START) begin
            n_last_q   <= prod - ProdW'(1);
            last_i_q   <= CONTROL_SIZE'(SIZE_I_IN - DATA_SIZE'(1));
            last_j_q   <= CONTROL_SIZE'(SIZE_J_IN - DATA_SIZE'(1));
            row_step_q <= CONTROL_SIZE'(SIZE_J_IN);
            wr_q       <= '0;
            i_q        <= '0;
            j_q        <= '0;
            offset_q   <= '0;
            if (SIZE_I_IN == '0 || SIZE_J_IN == '0) begin
              READY <= 1'b1;
            end else if (prod > Depth) begin
              READY <= 1'b1;
              ERROR <= 1'b1;
            end else begin
              state_q <= StLoading;
            end
          end
        end
        StLoading: begin
          if (LOAD_ENABLE) begin
            wr_q <= wr_q + CONTROL_SIZE'(1);
            if (ProdW'(wr_q) == n_last_q) begin
              state_q <= StFirst;
            end
          end
        end
        StFirst: begin
          // First element goes out unsolicited.
          DATA_OUT          <= mem_q[AddrZero];
          DATA_OUT_I_ENABLE <= 1'b1;
          DATA_OUT_J_ENABLE <= 1'b1;
          state_q           <= StStream;
        end
        StStream: begin
          if (DATA_REQUEST_ENABLE) begin
            if (j_q < last_j_q) begin
              j_q               <= j_q + CONTROL_SIZE'(1);
              DATA_OUT          <= mem_q[addr_next_j];
              DATA_OUT_J_ENABLE <= 1'b1;
            end else if (i_q < last_i_q) begin
              j_q               <= '0;
              i_q               <= i_q + CONTROL_SIZE'(1);
              offset_q          <= offset_q + row_step_q;
              DATA_OUT          <= mem_q[addr_next_row];
              DATA_OUT_I_ENABLE <= 1'b1;
              DATA_OUT_J_ENABLE <= 1'b1;
            end else begin
              READY   <= 1'b1;
              state_q <= StStarter;
            end
          end
        end
        default: state_q <= StStarter;
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_matrix_stream_source.sv
// Scoreboard bench: stimulus pushes expected elements/READY events, a negedge monitor pops them.
module tb_accelerator_matrix_stream_source;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        READY, ERROR;
  logic [63:0] SIZE_I_IN = '0, SIZE_J_IN = '0;
  logic        LOAD_ENABLE = 1'b0;
  logic [63:0] LOAD_DATA = '0;
  logic        DATA_REQUEST_ENABLE = 1'b0;
  logic        DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE;
  logic [63:0] DATA_OUT;

  accelerator_matrix_stream_source #(
    .DATA_SIZE(64), .CONTROL_SIZE(64), .ADDRESS_SIZE(8)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .ERROR(ERROR),
    .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN),
    .LOAD_ENABLE(LOAD_ENABLE), .LOAD_DATA(LOAD_DATA),
    .DATA_REQUEST_ENABLE(DATA_REQUEST_ENABLE),
    .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE), .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
    .DATA_OUT(DATA_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          rdy;
    bit          err;
    bit          i_en;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] last_data = '0;
  logic [63:0] mat [256];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_elem(input bit i_en, input logic [63:0] d);
    exp_t e;
    e.rdy = 1'b0; e.err = 1'b0; e.i_en = i_en; e.data = d; e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic push_ready(input bit err);
    exp_t e;
    e.rdy = 1'b1; e.err = err; e.i_en = 1'b0; e.data = '0; e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the scoreboard, with exact cycle.
  always @(negedge CLK) begin
    if (RST) begin
      last_data = '0;
    end else begin
      if (DATA_OUT_I_ENABLE) chk("i_needs_j", DATA_OUT_J_ENABLE, 1);
      if (DATA_OUT_J_ENABLE) begin
        if (exp_q.size() == 0 || exp_q[0].rdy) begin
          chk("unexpected_element", DATA_OUT_J_ENABLE, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data", DATA_OUT, mon_e.data);
          chk("i_enable", DATA_OUT_I_ENABLE, mon_e.i_en);
          chk("elem_latency", cyc, mon_e.cyc);
        end
        last_data = DATA_OUT;
      end else begin
        chk("data_hold", DATA_OUT, last_data);
      end
      if (READY) begin
        if (exp_q.size() == 0 || !exp_q[0].rdy) begin
          chk("unexpected_ready", READY, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("error", ERROR, mon_e.err);
          chk("ready_latency", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic do_start(input int si, input int sj);
    SIZE_I_IN = 64'(si);
    SIZE_J_IN = 64'(sj);
    START = 1'b1;
    if (si == 0 || sj == 0) push_ready(1'b0);
    else if (si * sj > 256) push_ready(1'b1);
    tick();
    START = 1'b0;
    // Garbage sizes afterwards must not matter.
    SIZE_I_IN = 64'hff;
    SIZE_J_IN = 64'h3;
  endtask

  task automatic noise_on(input bit in_load);
    START = 1'b1;
    SIZE_I_IN = 64'd1;
    SIZE_J_IN = 64'd1;
    if (in_load) begin
      DATA_REQUEST_ENABLE = 1'b1;
    end else begin
      LOAD_ENABLE = 1'b1;
      LOAD_DATA = 64'hdead;
    end
  endtask

  task automatic noise_off();
    START = 1'b0;
    DATA_REQUEST_ENABLE = 1'b0;
    LOAD_ENABLE = 1'b0;
  endtask

  task automatic load_all(input int n, input int gap, input bit noise);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        repeat (gap) begin
          if (noise) noise_on(1'b1);
          tick();
          noise_off();
        end
      end
      LOAD_ENABLE = 1'b1;
      LOAD_DATA = mat[k];
      tick();
      LOAD_ENABLE = 1'b0;
    end
    push_elem(1'b1, mat[0]);
    tick();
  endtask

  task automatic stream_all(input int si, input int sj, input int spacing, input bit noise);
    for (int k = 1; k <= si * sj; k++) begin
      DATA_REQUEST_ENABLE = 1'b1;
      if (k < si * sj) push_elem((k % sj) == 0, mat[k]);
      else push_ready(1'b0);
      tick();
      DATA_REQUEST_ENABLE = 1'b0;
      if (k < si * sj) begin
        repeat (spacing - 1) begin
          if (noise) noise_on(1'b0);
          tick();
          noise_off();
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ready"}, READY, 0);
    chk({tag, "_error"}, ERROR, 0);
    chk({tag, "_i_en"}, DATA_OUT_I_ENABLE, 0);
    chk({tag, "_j_en"}, DATA_OUT_J_ENABLE, 0);
    chk({tag, "_data"}, DATA_OUT, 0);
  endtask

  task automatic set_2x3();
    mat[0] = 64'd10; mat[1] = 64'd11; mat[2] = 64'd12;
    mat[3] = 64'd20; mat[4] = 64'd21; mat[5] = 64'd22;
  endtask

  initial begin
    tick();
    tick();
    check_outputs_zero("por");
    RST = 1'b0;
    tick();

    // 2x3 baseline.
    set_2x3();
    do_start(2, 3);
    load_all(6, 0, 1'b0);
    stream_all(2, 3, 1, 1'b0);

    // Reset mid-stream of a 2x2, then a normal transaction.
    mat[0] = 64'h31; mat[1] = 64'h32; mat[2] = 64'h33; mat[3] = 64'h34;
    do_start(2, 2);
    load_all(4, 0, 1'b0);
    DATA_REQUEST_ENABLE = 1'b1;
    push_elem(1'b0, mat[1]);
    tick();
    DATA_REQUEST_ENABLE = 1'b0;
    tick();
    DATA_REQUEST_ENABLE = 1'b1;
    RST = 1'b1;
    tick();
    check_outputs_zero("rst");
    tick();
    RST = 1'b0;
    DATA_REQUEST_ENABLE = 1'b0;
    repeat (3) tick();
    check_outputs_zero("post_rst");
    do_start(2, 2);
    load_all(4, 0, 1'b0);
    stream_all(2, 2, 1, 1'b0);

    // Load stalls and spaced requests.
    mat[0] = 64'h100; mat[1] = 64'h101; mat[2] = 64'h102; mat[3] = 64'h103;
    do_start(1, 4);
    load_all(4, 2, 1'b0);
    stream_all(1, 4, 3, 1'b0);

    // Zero size and overflow.
    do_start(0, 5);
    repeat (2) tick();
    do_start(17, 16);
    LOAD_ENABLE = 1'b1;
    LOAD_DATA = 64'hbad;
    repeat (3) tick();
    LOAD_ENABLE = 1'b0;
    repeat (2) tick();

    // Ignored START/LOAD/request noise must not disturb the 2x3 sequence.
    set_2x3();
    do_start(2, 3);
    load_all(6, 1, 1'b1);
    stream_all(2, 3, 2, 1'b1);

    // Exact fit 16x16.
    for (int k = 0; k < 256; k++) mat[k] = 64'h5000 + 64'(k);
    do_start(16, 16);
    load_all(256, 0, 1'b0);
    stream_all(16, 16, 1, 1'b0);

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
